flit_inject: RTL and testbench



---
 rtl/router_pkg.sv | 50 +++++
 rtl/flit_inject_if.sv | 15 +
 rtl/flit_inject_fifo.sv | 50 +++++
 rtl/flit_inject.sv | 106 ++++++++++
 tb/tb_flit_inject.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// Shared torus-router definitions: direction codes, torus size, flit field
// layout and a flit pack/unpack helper used by inject and route_comp.
package router_pkg;

  localparam int XSIZE = 4;
  localparam int YSIZE = 4;
  localparam int ZSIZE = 4;

  localparam int DIR_XPOS   = 0;
  localparam int DIR_XNEG   = 1;
  localparam int DIR_YPOS   = 2;
  localparam int DIR_YNEG   = 3;
  localparam int DIR_ZPOS   = 4;
  localparam int DIR_ZNEG   = 5;
  localparam int DIR_INJECT = 6;

  localparam int PayloadWidth   = 72;
  localparam int DstPos         = 72;
  localparam int DstWidth       = 9;
  localparam int Dst_XWidth     = 3;
  localparam int ValidBitPos    = 81;
  localparam int ChildrenPos    = 82;
  localparam int FlitChildWidth = 3;
  localparam int FlitWidth      = ChildrenPos + FlitChildWidth;

  typedef logic [FlitWidth-1:0] flit_t;

  typedef struct packed {
    logic [FlitChildWidth-1:0] children;
    logic                      valid;
    logic [DstWidth-1:0]       dst;
    logic [PayloadWidth-1:0]   payload;
  } flit_fields_t;

  function automatic flit_t pack_flit(input logic [FlitChildWidth-1:0] children,
                                      input logic [DstWidth-1:0]       dst,
                                      input logic [PayloadWidth-1:0]   payload);
    flit_fields_t f;
    f.children = children;
    f.valid    = 1'b1;
    f.dst      = dst;
    f.payload  = payload;
    return flit_t'(f);
  endfunction

  function automatic flit_fields_t unpack_flit(input flit_t f);
    return flit_fields_t'(f);
  endfunction

endpackage

// File: rtl/flit_inject_if.sv
// Local processing-element message handshake into the injection endpoint.
interface flit_inject_if;
  import router_pkg::*;

  logic                      msg_valid;
  logic                      msg_ready;
  logic [DstWidth-1:0]       msg_dst;
  logic [FlitChildWidth-1:0] msg_children;
  logic [PayloadWidth-1:0]   msg_payload;

  modport master (output msg_valid, msg_dst, msg_children, msg_payload,
                  input  msg_ready);
  modport slave  (input  msg_valid, msg_dst, msg_children, msg_payload,
                  output msg_ready);
endinterface

// File: rtl/flit_inject_fifo.sv
// Synchronous message FIFO for the injection endpoint; head is the oldest entry.
module inj_fifo #(
  parameter int WIDTH = 85,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/flit_inject.sv
// Injection endpoint: buffers local messages, loops back self-addressed ones
// and injects the rest into the router under credit-based flow control.
module flit_inject
  import router_pkg::*;
#(
  parameter int cur_x       = 0,
  parameter int cur_y       = 0,
  parameter int cur_z       = 0,
  parameter int DstPos      = router_pkg::DstPos,
  parameter int DstWidth    = router_pkg::DstWidth,
  parameter int Dst_XWidth  = router_pkg::Dst_XWidth,
  parameter int ValidBitPos = router_pkg::ValidBitPos,
  parameter int DEPTH       = 4,
  parameter int CREDITS     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  flit_inject_if.slave         msg,
  output logic [FlitWidth-1:0] flit_out,
  output logic                 flit_valid_out,
  input  logic                 credit_in,
  output logic [FlitWidth-1:0] loop_flit,
  output logic                 loop_valid,
  output logic [15:0]          inj_count,
  output logic                 credit_err
);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int CRW = $clog2(CREDITS + 1);
  localparam logic [DstWidth-1:0] SelfDst =
    DstWidth'({Dst_XWidth'(cur_z), Dst_XWidth'(cur_y), Dst_XWidth'(cur_x)});

  logic [FlitWidth-1:0] entry, head;
  logic [CW-1:0]        count, next_count;
  logic [CRW-1:0]       credits;
  logic                 full, empty, accept, push, pop;
  logic                 head_self, issue_net, issue_loop;

  assign accept = msg.msg_valid && msg.msg_ready;
  assign push   = accept && !full;

  always_comb begin
    entry                              = '0;
    entry[FlitWidth-1:ValidBitPos+1]   = msg.msg_children;
    entry[ValidBitPos]                 = 1'b1;
    entry[DstPos +: DstWidth]          = msg.msg_dst;
    entry[DstPos-1:0]                  = msg.msg_payload;
  end

  inj_fifo #(.WIDTH(FlitWidth), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (entry),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // A stalled network head blocks everything behind it, loopbacks included.
  assign head_self  = (head[DstPos +: DstWidth] == SelfDst);
  assign issue_loop = !empty && head_self;
  assign issue_net  = !empty && !head_self && (credits != '0);
  assign pop        = issue_loop || issue_net;

  always_comb begin
    next_count = count;
    unique case ({push, pop})
      2'b10:   next_count = count + 1'b1;
      2'b01:   next_count = count - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msg.msg_ready  <= 1'b0;
      flit_out       <= '0;
      flit_valid_out <= 1'b0;
      loop_flit      <= '0;
      loop_valid     <= 1'b0;
      inj_count      <= '0;
      credit_err     <= 1'b0;
      credits        <= CRW'(CREDITS);
    end else begin
      msg.msg_ready  <= (next_count < CW'(DEPTH));
      flit_valid_out <= issue_net;
      loop_valid     <= issue_loop;
      if (issue_net) begin
        flit_out  <= head;
        inj_count <= inj_count + 1'b1;
      end
      if (issue_loop) loop_flit <= head;
      unique case ({issue_net, credit_in})
        2'b10: credits <= credits - 1'b1;
        2'b01: begin
          if (credits == CRW'(CREDITS)) credit_err <= 1'b1;
          else                          credits    <= credits + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flit_inject.sv
// Directed bench for flit_inject: latency, credit exhaustion, backpressure,
// loopback ordering, credit overflow and mid-stream reset.
module tb_flit_inject;
  import router_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 credit_in;
  logic [FlitWidth-1:0] flit_out, loop_flit;
  logic                 flit_valid_out, loop_valid, credit_err;
  logic [15:0]          inj_count;

  int n_vec = 0;
  int n_err = 0;
  int net_pulses = 0;
  int loop_pulses = 0;
  logic [72:0] evq[$];
  logic [72:0] exp_ev [12];

  always #5 clk = ~clk;

  flit_inject_if bus ();

  flit_inject #(.cur_x(0), .cur_y(0), .cur_z(0), .DEPTH(4), .CREDITS(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .msg            (bus),
    .flit_out       (flit_out),
    .flit_valid_out (flit_valid_out),
    .credit_in      (credit_in),
    .loop_flit      (loop_flit),
    .loop_valid     (loop_valid),
    .inj_count      (inj_count),
    .credit_err     (credit_err)
  );

  always @(negedge clk) begin
    if (flit_valid_out) begin
      net_pulses++;
      evq.push_back({1'b0, flit_out[71:0]});
    end
    if (loop_valid) begin
      loop_pulses++;
      evq.push_back({1'b1, loop_flit[71:0]});
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] ch, input logic [8:0] dst, input logic [71:0] pl);
    int w = 0;
    bus.msg_children = ch;
    bus.msg_dst      = dst;
    bus.msg_payload  = pl;
    bus.msg_valid    = 1'b1;
    while (!bus.msg_ready && w < 50) begin
      tick();
      w++;
    end
    if (w >= 50) check("send_timeout", bus.msg_ready, 1);
    tick();
    bus.msg_valid = 1'b0;
  endtask

  initial begin
    int base, n_ev;
    exp_ev[0] = {1'b0, 72'hAB};
    for (int i = 1; i <= 9; i++) exp_ev[i] = {1'b0, 72'(i)};
    exp_ev[10] = {1'b1, 72'd10};
    exp_ev[11] = {1'b0, 72'd11};

    rst = 1'b0;
    credit_in = 1'b0;
    bus.msg_valid = 1'b0;
    bus.msg_dst = '0;
    bus.msg_children = '0;
    bus.msg_payload = '0;
    repeat (2) tick();
    check("rst_ready", bus.msg_ready, 0);
    check("rst_fvalid", flit_valid_out, 0);
    check("rst_lvalid", loop_valid, 0);
    check("rst_cerr", credit_err, 0);
    check("rst_inj", inj_count, 0);
    check("rst_flit", flit_out, 0);
    check("rst_loop", loop_flit, 0);
    rst = 1'b1;
    tick();
    check("ready_after_rel", bus.msg_ready, 1);

    // single message, one-cycle issue latency
    bus.msg_children = 3'd3;
    bus.msg_dst = 9'h042;
    bus.msg_payload = 72'hAB;
    bus.msg_valid = 1'b1;
    tick();
    bus.msg_valid = 1'b0;
    check("lat_not_yet", flit_valid_out, 0);
    tick();
    check("single_valid", flit_valid_out, 1);
    check("single_flit", flit_out, {3'd3, 1'b1, 9'h042, 72'hAB});
    check("single_inj", inj_count, 1);
    tick();
    check("single_pulse_end", flit_valid_out, 0);
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    check("refill_no_err", credit_err, 0);
    check("refill_credits", dut.credits, 4);

    // credit exhaustion
    base = net_pulses;
    for (int i = 1; i <= 6; i++) send(3'd0, 9'h001, 72'(i));
    repeat (4) tick();
    check("exh_pulses", net_pulses - base, 4);
    check("exh_fifo_count", dut.u_fifo.count, 2);
    check("exh_ready", bus.msg_ready, 1);
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    check("cred_not_same_edge", flit_valid_out, 0);
    tick();
    check("cred_issue", flit_valid_out, 1);
    check("cred_payload", flit_out[71:0], 72'd5);
    check("cred_inj", inj_count, 6);

    // backpressure with a held self-addressed message
    for (int i = 7; i <= 9; i++) send(3'd0, 9'h001, 72'(i));
    bus.msg_children = 3'd5;
    bus.msg_dst = 9'h000;
    bus.msg_payload = 72'd10;
    bus.msg_valid = 1'b1;
    repeat (3) tick();
    check("bp_ready", bus.msg_ready, 0);
    check("bp_count", dut.u_fifo.count, 4);
    check("bp_no_flit", flit_valid_out, 0);
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    tick();
    check("bp_ready_back", bus.msg_ready, 1);
    tick();
    bus.msg_valid = 1'b0;
    check("bp_full_again", bus.msg_ready, 0);

    // self-addressed entry stays blocked behind stalled network heads
    credit_in = 1'b1;
    repeat (4) tick();
    credit_in = 1'b0;
    check("lb_blocked", loop_pulses, 0);
    tick();
    check("lb_valid", loop_valid, 1);
    check("lb_flit", loop_flit, {3'd5, 1'b1, 9'h000, 72'd10});
    check("lb_no_net", flit_valid_out, 0);
    check("lb_credits", dut.credits, 1);

    send(3'd0, 9'h001, 72'd11);
    for (int i = 12; i <= 14; i++) send(3'd0, 9'h001, 72'(i));
    tick();
    check("pre_rst_inj", inj_count, 11);
    check("pre_rst_count", dut.u_fifo.count, 3);
    check("hold_flit", flit_out[71:0], 72'd11);

    // mid-stream asynchronous reset
    #2 rst = 1'b0;
    #1;
    check("mrst_ready", bus.msg_ready, 0);
    check("mrst_fvalid", flit_valid_out, 0);
    check("mrst_lvalid", loop_valid, 0);
    check("mrst_inj", inj_count, 0);
    check("mrst_flit", flit_out, 0);
    check("mrst_loop", loop_flit, 0);
    check("mrst_count", dut.u_fifo.count, 0);
    tick();
    rst = 1'b1;
    n_ev = evq.size();
    tick();
    check("mrst_ready_rise", bus.msg_ready, 1);
    repeat (4) tick();
    check("mrst_no_stale", evq.size(), n_ev);

    // credit overflow is sticky until reset
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    check("cerr_set", credit_err, 1);
    check("cerr_credits", dut.credits, 4);
    repeat (3) tick();
    check("cerr_sticky", credit_err, 1);
    rst = 1'b0;
    #1;
    check("cerr_cleared", credit_err, 0);
    rst = 1'b1;
    tick();

    check("ev_total", evq.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < evq.size()) check($sformatf("ev_order%0d", i), evq[i], exp_ev[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
